// File: rtl/sm_run_ctrl_pkg.sv
// Shared types and default widths for the schoolMIPS run/step/scan controller.
package sm_run_ctrl_pkg;

  typedef enum logic [2:0] {IDLE, RUN, STEP, SCAN} state_t;
  typedef enum logic {PH_A, PH_B} phase_t;

  localparam int DEF_DIV_W  = 4;
  localparam int DEF_ADDR_W = 4;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_STEP_W = 8;

endpackage

// File: rtl/sm_ce_div.sv
// Programmable clock-enable divider: registered pulse each time cnt reaches i_div.
module sm_ce_div
  import sm_run_ctrl_pkg::*;
#(
  parameter int DIV_W = DEF_DIV_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clr,
  input  logic [DIV_W-1:0] i_div,
  output logic             o_fire,
  output logic             o_ce
);

  logic [DIV_W-1:0] r_cnt;
  logic             r_ce;

  // >= lets a lowered divide value take effect without wrapping the counter
  assign o_fire = !i_clr && (r_cnt >= i_div);
  assign o_ce   = r_ce;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_ce  <= 1'b0;
    end else if (i_clr) begin
      r_cnt <= '0;
      r_ce  <= 1'b0;
    end else if (o_fire) begin
      r_cnt <= '0;
      r_ce  <= 1'b1;
    end else begin
      r_cnt <= r_cnt + DIV_W'(1);
      r_ce  <= 1'b0;
    end
  end

endmodule

// File: rtl/sm_run_ctrl.sv
// Run/step/scan controller for schoolMIPS: core clock-enable, step bursts, register scan-out.
// Optional breakpoint-to-scan in RUN when SM_RUN_CTRL_BREAKPOINT_EN is defined.
//
// state | meaning
// IDLE  | core stopped, reg_addr follows dbg_addr
// RUN   | core_ce free-running at the divided rate
// STEP  | core_ce issued until the step count is exhausted
// SCAN  | two cycles per register, streaming snapshots out
module sm_run_ctrl
  import sm_run_ctrl_pkg::*;
#(
  parameter int DIV_W  = DEF_DIV_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int STEP_W = DEF_STEP_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_run_req,
  input  logic              i_halt_req,
  input  logic              i_step_req,
  input  logic [STEP_W-1:0] i_step_num,
  input  logic [DIV_W-1:0]  i_clk_devide,
  input  logic [ADDR_W-1:0] i_dbg_addr,
  output logic              o_core_ce,
  output logic [ADDR_W-1:0] o_reg_addr,
  input  logic [DATA_W-1:0] i_reg_data,
  output logic              o_snap_valid,
  output logic [ADDR_W-1:0] o_snap_addr,
  output logic [DATA_W-1:0] o_snap_data,
  output logic              o_busy,
`ifdef SM_RUN_CTRL_BREAKPOINT_EN
  input  logic [31:0]       i_pc,
  input  logic [31:0]       i_bp_addr,
  input  logic [0:0]        i_bp_en,
  output logic              o_bp_hit,
`endif
  output logic              o_done
);

  state_t            r_state;
  phase_t            r_phase;
  logic [STEP_W-1:0] r_stepcnt;
  logic [ADDR_W-1:0] r_idx;
  logic              r_busy;
  logic              r_snap_valid;
  logic [ADDR_W-1:0] r_snap_addr;
  logic [DATA_W-1:0] r_snap_data;
  logic              r_done;

  logic w_active;
  logic w_div_clr;
  logic w_fire;
  logic w_bp_match;

`ifdef SM_RUN_CTRL_BREAKPOINT_EN
  logic r_bp_hit;
  assign w_bp_match = i_bp_en[0] && (i_pc == i_bp_addr);
  assign o_bp_hit   = r_bp_hit;
`else
  assign w_bp_match = 1'b0;
`endif

  assign w_active = (r_state == RUN) || (r_state == STEP);
  // A halt in RUN suppresses the pulse on the same edge; in STEP the final pulse still goes out
  assign w_div_clr = !w_active || ((r_state == RUN) && i_halt_req);

  sm_ce_div #(.DIV_W(DIV_W)) u_ce_div (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_clr  (w_div_clr),
    .i_div  (i_clk_devide),
    .o_fire (w_fire),
    .o_ce   (o_core_ce)
  );

  assign o_reg_addr   = (r_state == SCAN) ? r_idx : i_dbg_addr;
  assign o_busy       = r_busy;
  assign o_snap_valid = r_snap_valid;
  assign o_snap_addr  = r_snap_addr;
  assign o_snap_data  = r_snap_data;
  assign o_done       = r_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_phase      <= PH_A;
      r_stepcnt    <= '0;
      r_idx        <= '0;
      r_busy       <= 1'b0;
      r_snap_valid <= 1'b0;
      r_snap_addr  <= '0;
      r_snap_data  <= '0;
      r_done       <= 1'b0;
`ifdef SM_RUN_CTRL_BREAKPOINT_EN
      r_bp_hit     <= 1'b0;
`endif
    end else begin
      r_snap_valid <= 1'b0;
      r_done       <= 1'b0;
`ifdef SM_RUN_CTRL_BREAKPOINT_EN
      r_bp_hit     <= 1'b0;
`endif
      if (r_state != SCAN) begin
        r_idx   <= '0;
        r_phase <= PH_A;
      end
      case (r_state)
        IDLE: begin
          if (i_run_req) begin
            r_state <= RUN;
            r_busy  <= 1'b1;
          end else if (i_step_req) begin
            r_state   <= STEP;
            r_busy    <= 1'b1;
            r_stepcnt <= (i_step_num == '0) ? STEP_W'(1) : i_step_num;
          end
        end
        RUN: begin
          if (i_halt_req) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end else if (w_fire && w_bp_match) begin
            r_state  <= SCAN;
`ifdef SM_RUN_CTRL_BREAKPOINT_EN
            r_bp_hit <= 1'b1;
`endif
          end
        end
        STEP: begin
          if (w_fire) r_stepcnt <= r_stepcnt - STEP_W'(1);
          if (i_halt_req) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end else if (w_fire && (r_stepcnt == STEP_W'(1))) begin
            r_state <= SCAN;
          end
        end
        SCAN: begin
          if (i_halt_req) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end else if (r_phase == PH_A) begin
            r_phase <= PH_B;
          end else begin
            r_snap_data  <= i_reg_data;
            r_snap_addr  <= r_idx;
            r_snap_valid <= 1'b1;
            if (r_idx == '1) begin
              r_done  <= 1'b1;
              r_state <= IDLE;
              r_busy  <= 1'b0;
            end else begin
              r_idx   <= r_idx + ADDR_W'(1);
              r_phase <= PH_A;
            end
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sm_run_ctrl.sv
// Self-checking bench for sm_run_ctrl: step-burst vector table plus run, halt and reset sequences.
module tb_sm_run_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        run_req = 1'b0;
  logic        halt_req = 1'b0;
  logic        step_req = 1'b0;
  logic [7:0]  step_num = 8'd0;
  logic [3:0]  clk_devide = 4'd0;
  logic [3:0]  dbg_addr = 4'd9;
  logic        core_ce;
  logic [3:0]  reg_addr;
  logic [31:0] reg_data;
  logic        snap_valid;
  logic [3:0]  snap_addr;
  logic [31:0] snap_data;
  logic        busy;
  logic        done;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  // Model register file seen by the debug port
  function automatic logic [31:0] regval(input logic [3:0] a);
    return {16'hBEE0, 4'h0, a, ~a, a};
  endfunction

  assign reg_data = regval(reg_addr);

  sm_run_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_run_req    (run_req),
    .i_halt_req   (halt_req),
    .i_step_req   (step_req),
    .i_step_num   (step_num),
    .i_clk_devide (clk_devide),
    .i_dbg_addr   (dbg_addr),
    .o_core_ce    (core_ce),
    .o_reg_addr   (reg_addr),
    .i_reg_data   (reg_data),
    .o_snap_valid (snap_valid),
    .o_snap_addr  (snap_addr),
    .o_snap_data  (snap_data),
    .o_busy       (busy),
    .o_done       (done)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_core_ce"}, 32'(core_ce), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_snap_valid"}, 32'(snap_valid), 32'd0);
    check({tag, "_snap_addr"}, 32'(snap_addr), 32'd0);
    check({tag, "_snap_data"}, snap_data, 32'd0);
    check({tag, "_reg_addr"}, 32'(reg_addr), 32'(dbg_addr));
  endtask

  typedef struct {
    logic [7:0] step_num;
    logic [3:0] div;
    int         exp_pulses;
    int         exp_first_ce;
    int         exp_first_snap;
  } vec_t;

  vec_t vecs[4];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  k, pulses, first_ce, last_ce, first_snap, last_snap, nsnap, gap_err, cnt_a, cnt_b, cnt_c;
    bit  got_done, found;

    // k counts negedges after the edge that accepted the request
    vecs[0] = '{8'd5, 4'd0, 5, 1, 7};
    vecs[1] = '{8'd0, 4'd0, 1, 1, 3};
    vecs[2] = '{8'd3, 4'd2, 3, 3, 11};
    vecs[3] = '{8'd2, 4'd3, 2, 4, 10};

    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check_idle_outputs("post_reset");

    for (int v = 0; v < 4; v++) begin
      step_num   = vecs[v].step_num;
      clk_devide = vecs[v].div;
      step_req   = 1'b1;
      @(negedge clk);
      step_req = 1'b0;
      k = 0; pulses = 0; first_ce = -1; last_ce = 0; first_snap = -1; last_snap = 0;
      nsnap = 0; gap_err = 0; got_done = 1'b0;
      while (!got_done && k < 400) begin
        if (core_ce) begin
          if (pulses == 0) first_ce = k;
          else if ((k - last_ce) != (int'(vecs[v].div) + 1)) gap_err++;
          last_ce = k;
          pulses++;
        end
        if (snap_valid) begin
          if (nsnap == 0) first_snap = k;
          else if ((k - last_snap) != 2) gap_err++;
          check("snap_addr", 32'(snap_addr), 32'(nsnap[3:0]));
          check("snap_data", snap_data, regval(nsnap[3:0]));
          last_snap = k;
          nsnap++;
        end
        if (done) begin
          got_done = 1'b1;
          check("done_addr", 32'(snap_addr), 32'd15);
          check("done_with_valid", 32'(snap_valid), 32'd1);
        end
        if (!got_done) begin
          @(negedge clk);
          k++;
        end
      end
      check("step_done_seen", 32'(got_done), 32'd1);
      check("step_pulses", 32'(pulses), 32'(vecs[v].exp_pulses));
      check("step_first_ce", 32'(first_ce), 32'(vecs[v].exp_first_ce));
      check("step_first_snap", 32'(first_snap), 32'(vecs[v].exp_first_snap));
      check("step_nsnap", 32'(nsnap), 32'd16);
      check("step_gaps", 32'(gap_err), 32'd0);
      check("step_done_time", 32'(k), 32'(vecs[v].exp_first_snap + 30));
      @(negedge clk);
      check("step_busy_after", 32'(busy), 32'd0);
      check("step_done_after", 32'(done), 32'd0);
      check("step_reg_addr_after", 32'(reg_addr), 32'(dbg_addr));
      repeat (2) @(negedge clk);
    end

    // Free run at divide-by-4, halted after 20 cycles
    clk_devide = 4'd3;
    run_req = 1'b1;
    @(negedge clk);
    run_req = 1'b0;
    pulses = 0; first_ce = -1;
    for (int i = 0; i <= 20; i++) begin
      if (core_ce) begin
        if (pulses == 0) first_ce = i;
        pulses++;
      end
      if (i < 20) @(negedge clk);
    end
    check("run_pulses", 32'(pulses), 32'd5);
    check("run_first_ce", 32'(first_ce), 32'd4);
    check("run_busy_before_halt", 32'(busy), 32'd1);
    halt_req = 1'b1;
    @(negedge clk);
    halt_req = 1'b0;
    check("run_busy_after_halt", 32'(busy), 32'd0);
    cnt_a = 0;
    for (int i = 0; i < 20; i++) begin
      if (core_ce) cnt_a++;
      @(negedge clk);
    end
    check("run_no_ce_after_halt", 32'(cnt_a), 32'd0);

    // Simultaneous run and step: run wins, no scan at halt
    clk_devide = 4'd0;
    step_num   = 8'd3;
    run_req    = 1'b1;
    step_req   = 1'b1;
    @(negedge clk);
    run_req  = 1'b0;
    step_req = 1'b0;
    pulses = 0;
    for (int i = 0; i <= 10; i++) begin
      if (core_ce) pulses++;
      if (i < 10) @(negedge clk);
    end
    check("runstep_pulses", 32'(pulses), 32'd10);
    halt_req = 1'b1;
    @(negedge clk);
    halt_req = 1'b0;
    check("runstep_busy_after_halt", 32'(busy), 32'd0);
    cnt_a = 0; cnt_b = 0; cnt_c = 0;
    for (int i = 0; i < 40; i++) begin
      if (core_ce) cnt_a++;
      if (snap_valid) cnt_b++;
      if (done) cnt_c++;
      @(negedge clk);
    end
    check("runstep_no_ce", 32'(cnt_a), 32'd0);
    check("runstep_no_snap", 32'(cnt_b), 32'd0);
    check("runstep_no_done", 32'(cnt_c), 32'd0);

    // Halt in SCAN right after the snapshot of register 6
    step_num   = 8'd1;
    clk_devide = 4'd0;
    step_req   = 1'b1;
    @(negedge clk);
    step_req = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      if (snap_valid && snap_addr == 4'd6) found = 1'b1;
      else @(negedge clk);
    end
    check("scanhalt_reached", 32'(found), 32'd1);
    check("scanhalt_reg_addr_scan", 32'(reg_addr), 32'd7);
    halt_req = 1'b1;
    @(negedge clk);
    halt_req = 1'b0;
    check("scanhalt_reg_addr_dbg", 32'(reg_addr), 32'(dbg_addr));
    check("scanhalt_busy", 32'(busy), 32'd0);
    cnt_b = 0; cnt_c = 0;
    for (int i = 0; i < 40; i++) begin
      if (snap_valid) cnt_b++;
      if (done) cnt_c++;
      @(negedge clk);
    end
    check("scanhalt_no_snap", 32'(cnt_b), 32'd0);
    check("scanhalt_no_done", 32'(cnt_c), 32'd0);

    // Asynchronous reset with three step cycles still pending
    step_num   = 8'd6;
    clk_devide = 4'd3;
    step_req   = 1'b1;
    @(negedge clk);
    step_req = 1'b0;
    pulses = 0;
    found  = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      if (core_ce) pulses++;
      if (pulses == 3) found = 1'b1;
      else @(negedge clk);
    end
    check("rst_mid_step_reached", 32'(found), 32'd1);
    check("rst_mid_step_ce_high", 32'(core_ce), 32'd1);
    rst_n = 1'b0;
    #1;
    check_idle_outputs("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    cnt_a = 0; cnt_b = 0;
    for (int i = 0; i < 30; i++) begin
      if (core_ce) cnt_a++;
      if (busy) cnt_b++;
      @(negedge clk);
    end
    check("post_rst_no_ce", 32'(cnt_a), 32'd0);
    check("post_rst_no_busy", 32'(cnt_b), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
